// File: rtl/lz4_pkg.sv
// Shared constants and helpers for the LZ4/Huffman datapath buffers.
package lz4_pkg;

    localparam int MATCH_FIFO_DATA_W = 47;
    localparam int MATCH_FIFO_DEPTH  = 16;
    localparam int LIT_FIFO_DATA_W   = 64;
    localparam int LIT_FIFO_DEPTH    = 16;

    // Smallest n with 2**n >= value; usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int i = 0; i < 32; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 32'sd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/lz4_fifo_ptr_ctrl.sv
// Pointer, occupancy, watermark and sticky error bookkeeping for lz4_sync_fifo.
module lz4_fifo_ptr_ctrl
    import lz4_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int AW       = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic          wr_accept,
    output logic          rd_accept,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [AW:0]   data_count,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW-1:0] PTR_INC   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_INC   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_AF    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0]   CNT_AE    = (AW+1)'(AE_LEVEL);

    logic [AW:0] count_next;

    // Gating on the registered flags makes a full FIFO favour the read and an empty one the write.
    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next = data_count;
        if (wr_accept && !rd_accept) begin
            count_next = data_count + CNT_INC;
        end else if (rd_accept && !wr_accept) begin
            count_next = data_count - CNT_INC;
        end else begin
            count_next = data_count;
        end
    end

    // Pointers wrap modulo DEPTH; status flags are registered from the next-state count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= {AW{1'b0}};
            rd_ptr       <= {AW{1'b0}};
            data_count   <= CNT_ZERO;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_INC;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PTR_INC;
            end
            data_count   <= count_next;
            empty        <= (count_next == CNT_ZERO);
            full         <= (count_next == CNT_DEPTH);
            almost_full  <= (count_next >= CNT_AF);
            almost_empty <= (count_next <= CNT_AE);
            overflow     <= overflow | (wr_en & full);
            underflow    <= underflow | (rd_en & empty);
        end
    end

endmodule

// File: rtl/lz4_sync_fifo.sv
// Parametrised single-clock FIFO with watermarks and sticky error flags.
// Define LZ4_FIFO_FWFT_EN for first-word-fall-through; otherwise dout is a registered read.
module lz4_sync_fifo
    import lz4_pkg::*;
#(
    parameter int DATA_W   = MATCH_FIFO_DATA_W,
    parameter int DEPTH    = MATCH_FIFO_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       data_count,
    output logic              overflow,
    output logic              underflow
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_accept;
    logic              rd_accept;

    lz4_fifo_ptr_ctrl #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL),
        .AW       (AW)
    ) u_ptr_ctrl (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .wr_accept    (wr_accept),
        .rd_accept    (rd_accept),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .data_count   (data_count),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Storage is deliberately left out of reset; stale words stay hidden behind the pointers.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= din;
        end
    end

`ifdef LZ4_FIFO_FWFT_EN
    // Head word is shown directly; masked while empty so nothing stale leaks out.
    assign dout  = empty ? {DATA_W{1'b0}} : mem[rd_ptr];
    assign valid = !empty;
`else
    // Registered read: dout loads on an accepted pop and holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout  <= {DATA_W{1'b0}};
            valid <= 1'b0;
        end else begin
            valid <= rd_accept;
            if (rd_accept) begin
                dout <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_lz4_sync_fifo.sv
// Self-checking bench for lz4_sync_fifo: vector table, directed corner sequences and a random run vs a queue model.
module tb_lz4_sync_fifo;

    localparam int DATA_W   = 47;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 14;
    localparam int AE_LEVEL = 2;
    localparam int AW       = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] din;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              valid;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic [AW:0]       data_count;
    logic              overflow;
    logic              underflow;

    lz4_sync_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .dout         (dout),
        .valid        (valid),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .data_count   (data_count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain queue of stored words plus the sticky flags.
    logic [DATA_W-1:0] q[$];
    bit                m_ovf;
    bit                m_unf;
    logic [DATA_W-1:0] m_dout;
    bit                m_valid;

    typedef struct {
        bit                we;
        bit                re;
        logic [DATA_W-1:0] d;
        int                cnt;
        bit                emp;
        bit                unf;
        bit                vld;
        logic [DATA_W-1:0] dv;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [63:0] r64;
        r64 = {$urandom(), $urandom()};
        return r64[DATA_W-1:0];
    endfunction

    task automatic model_edge(input bit we, input bit re, input logic [DATA_W-1:0] d, input bit r);
        bit                was_full;
        bit                was_empty;
        logic [DATA_W-1:0] popped;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        popped    = '0;
        if (r) begin
            q.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_dout  = '0;
            m_valid = 1'b0;
        end else begin
            if (we && was_full) m_ovf = 1'b1;
            if (re && was_empty) m_unf = 1'b1;
            if (re && !was_empty) popped = q.pop_front();
            if (we && !was_full) q.push_back(d);
            m_valid = re && !was_empty;
            if (m_valid) m_dout = popped;
        end
    endtask

    // Drive inputs, take one rising edge, advance the model, then settle before sampling.
    task automatic cycle(input bit we, input bit re, input logic [DATA_W-1:0] d, input bit r);
        rst   = r;
        wr_en = we;
        rd_en = re;
        din   = d;
        @(posedge clk);
        model_edge(we, re, d, r);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [DATA_W-1:0] e_dout;
        bit                e_valid;
`ifdef LZ4_FIFO_FWFT_EN
        e_valid = (q.size() != 0);
        e_dout  = e_valid ? q[0] : '0;
`else
        e_valid = m_valid;
        e_dout  = m_dout;
`endif
        check({tag, ".dout"},         64'(dout),         64'(e_dout));
        check({tag, ".valid"},        64'(valid),        64'(e_valid));
        check({tag, ".count"},        64'(data_count),   64'(q.size()));
        check({tag, ".empty"},        64'(empty),        64'(q.size() == 0));
        check({tag, ".full"},         64'(full),         64'(q.size() == DEPTH));
        check({tag, ".almost_full"},  64'(almost_full),  64'(q.size() >= AF_LEVEL));
        check({tag, ".almost_empty"}, 64'(almost_empty), 64'(q.size() <= AE_LEVEL));
        check({tag, ".overflow"},     64'(overflow),     64'(m_ovf));
        check({tag, ".underflow"},    64'(underflow),    64'(m_unf));
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0; m_valid = 1'b0;

        // Hand-derived vectors from an empty FIFO: push A, push B, pop, push C + pop, pop, pop on empty.
        tbl[0] = '{1'b1, 1'b0, 47'hA, 1, 1'b0, 1'b0, 1'b0, 47'h0};
        tbl[1] = '{1'b1, 1'b0, 47'hB, 2, 1'b0, 1'b0, 1'b0, 47'h0};
        tbl[2] = '{1'b0, 1'b1, 47'h0, 1, 1'b0, 1'b0, 1'b1, 47'hA};
        tbl[3] = '{1'b1, 1'b1, 47'hC, 1, 1'b0, 1'b0, 1'b1, 47'hB};
        tbl[4] = '{1'b0, 1'b1, 47'h0, 0, 1'b1, 1'b0, 1'b1, 47'hC};
        tbl[5] = '{1'b0, 1'b1, 47'h0, 0, 1'b1, 1'b1, 1'b0, 47'hC};
`ifdef LZ4_FIFO_FWFT_EN
        tbl[0].vld = 1'b1; tbl[0].dv = 47'hA;
        tbl[1].vld = 1'b1; tbl[1].dv = 47'hA;
        tbl[2].vld = 1'b1; tbl[2].dv = 47'hB;
        tbl[3].vld = 1'b1; tbl[3].dv = 47'hC;
        tbl[4].vld = 1'b0; tbl[4].dv = 47'h0;
        tbl[5].vld = 1'b0; tbl[5].dv = 47'h0;
`endif

        cycle(1'b0, 1'b0, '0, 1'b1);
        check_all("reset");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b0);
            check_all("idle");
        end

        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].we, tbl[i].re, tbl[i].d, 1'b0);
            check("tbl.count",     64'(data_count), 64'(tbl[i].cnt));
            check("tbl.empty",     64'(empty),      64'(tbl[i].emp));
            check("tbl.underflow", 64'(underflow),  64'(tbl[i].unf));
            check("tbl.valid",     64'(valid),      64'(tbl[i].vld));
            check("tbl.dout",      64'(dout),       64'(tbl[i].dv));
        end

        // Fill to full, then one write too many.
        cycle(1'b0, 1'b0, '0, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 1'b0, DATA_W'(i), 1'b0);
            check_all("fill");
            check("fill.almost_full", 64'(almost_full), 64'(i >= 14));
        end
        check("fill.full", 64'(full), 64'(1'b1));
        check("fill.count16", 64'(data_count), 64'(5'b10000));
        cycle(1'b1, 1'b0, 47'h11, 1'b0);
        check_all("ovf");
        check("ovf.flag", 64'(overflow), 64'(1'b1));

        // Drain: 0x1..0x10 in order, the dropped 0x11 never appears.
        for (int i = 1; i <= 16; i++) begin
`ifdef LZ4_FIFO_FWFT_EN
            check("drain.head_dout", 64'(dout), 64'(i));
            check("drain.head_valid", 64'(valid), 64'(1'b1));
`endif
            cycle(1'b0, 1'b1, '0, 1'b0);
            check_all("drain");
`ifndef LZ4_FIFO_FWFT_EN
            check("drain.dout", 64'(dout), 64'(i));
            check("drain.valid", 64'(valid), 64'(1'b1));
`endif
        end
        check("drain.empty", 64'(empty), 64'(1'b1));
        cycle(1'b0, 1'b0, '0, 1'b0);
        check_all("drain.idle");

        // Simultaneous read/write at count 8 for 40 cycles: pointers wrap, count holds.
        cycle(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, rand_word(), 1'b0);
        check_all("wrap.pre");
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b1, rand_word(), 1'b0);
            check_all("wrap");
            check("wrap.count8", 64'(data_count), 64'(8));
        end

        // Underflow, then reset clears it and every output.
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b1, '0, 1'b0);
        check("unf.flag", 64'(underflow), 64'(1'b1));
        check("unf.count", 64'(data_count), 64'(0));
        check_all("unf");
        cycle(1'b0, 1'b0, '0, 1'b1);
        check("unf.rst_flag", 64'(underflow), 64'(1'b0));
        check_all("unf.rst");

        // Reset at count 5 with a write pending discards everything.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, rand_word(), 1'b0);
        check_all("midrst.pre");
        cycle(1'b1, 1'b0, rand_word(), 1'b1);
        check("midrst.count", 64'(data_count), 64'(0));
        check("midrst.empty", 64'(empty), 64'(1'b1));
        check("midrst.valid", 64'(valid), 64'(1'b0));
        check("midrst.dout", 64'(dout), 64'(0));
        cycle(1'b0, 1'b0, '0, 1'b0);
        check_all("midrst.idle");

        // Random traffic in phases biased toward filling, draining and balance.
        for (int i = 0; i < 600; i++) begin
            bit we;
            bit re;
            bit r;
            case ((i / 100) % 3)
                0:       begin we = ($urandom_range(0, 3) != 0); re = ($urandom_range(0, 3) == 0); end
                1:       begin we = ($urandom_range(0, 3) == 0); re = ($urandom_range(0, 3) != 0); end
                default: begin we = $urandom_range(0, 1) == 1;  re = $urandom_range(0, 1) == 1;  end
            endcase
            r = ($urandom_range(0, 149) == 0);
            cycle(we, re, rand_word(), r);
            check_all("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lz4_sync_fifo.md
# lz4_sync_fifo

Parametrised single-clock FIFO: the general buffer for the LZ4/Huffman datapath, replacing fixed-size BRAM-IP FIFOs in the match, sequence and token stages. Width and depth are set by parameters, and the occupancy counter is sized so a full FIFO is counted correctly. It adds almost-full/almost-empty watermarks and sticky overflow/underflow flags. Read mode is set at compile time: registered standard read, or first-word-fall-through.

## Interface
- DATA_W, 47: payload width in bits, ≥1.
- DEPTH, 16: number of entries; power of two, ≥4.
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  DATA_W  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request (pop acknowledge in FWFT mode).
- dout  out  DATA_W  read data.
- valid  out  1  dout holds a valid popped/head word.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- data_count  out  AW+1  occupancy 0..DEPTH; AW = log2(DEPTH).
- overflow  out  1  sticky: wr_en seen while full.
- underflow  out  1  sticky: rd_en seen while empty.

## Operation
- Storage: DEPTH×DATA_W array; wr_ptr and rd_ptr are AW bits wide and wrap modulo DEPTH naturally.
- Write is accepted when wr_en && !full; din goes to mem[wr_ptr], and wr_ptr increments.
- Read is accepted when rd_en && !empty; rd_ptr increments.
- Write while full is dropped; memory and pointers are unchanged; overflow sets.
- Read while empty is ignored; underflow sets.
- Flags clear only on rst.
- data_count changes by +1 on an accepted write only, by -1 on an accepted read only, and by 0 when both are accepted or neither is.
- Both accepted in one cycle: both pointers advance and the count holds.
- On full, rd_en && wr_en gives read accepted and write dropped, with overflow set.
- On empty, rd_en && wr_en gives write accepted and read ignored, with underflow set.
- empty, full, almost_* and data_count are registered, derived from the next-state count.
- Reset values:
  - dout = 0, valid = 0, empty = 1, full = 0.
  - almost_full = 0 (given AF_LEVEL ≥ 1).
  - almost_empty = 1, data_count = 0, overflow = underflow = 0.
  - Pointers = 0.
- rst asserted mid-operation discards all contents on that edge. Memory contents are not cleared and are not observable afterwards.

## Timing
- Standard mode:
  - dout is registered, loaded with mem[rd_ptr] on an accepted read.
  - valid is high exactly one cycle after each accepted read.
  - Read latency is 1 cycle; dout holds its value when no read occurs.
- FWFT mode:
  - dout = mem[rd_ptr] combinationally; valid = !empty.
  - A word written into an empty FIFO appears on dout with valid high in the cycle after the write edge.
  - rd_en pops the displayed word; the next word is shown in the following cycle.
- Flags update on the same edge as the accepted write or read.
- Back-to-back reads and writes sustain 1 word/cycle.

## Configuration
- LZ4_FIFO_FWFT_EN defined: first-word-fall-through timing as above.
- LZ4_FIFO_FWFT_EN undefined: standard registered read.
- Flags, counts and error behaviour are identical in both modes.

## Structure
- Shared package lz4_pkg holds:
  - the clog2 constant function;
  - default DATA_W/DEPTH constants for the match (47-bit) and literal (64-bit) FIFOs.
- One sub-module, lz4_fifo_ptr_ctrl, holds the pointers, count, all flags and error logic.
- The top holds the memory array and the dout/valid path.

## Test plan
- Reset, then idle 5 cycles: empty=1, almost_empty=1, data_count=0, valid=0, full=0.
- DEPTH=16; write 0x1..0x10 on consecutive cycles:
  - full=1 and data_count=16 (5'b10000);
  - almost_full=1 from count 14;
  - a 17th write of 0x11 sets overflow;
  - contents are unchanged.
- Drain the full FIFO of 0x1..0x10:
  - standard mode: dout sequence 0x1..0x10, each with valid one cycle after rd_en;
  - FWFT mode: dout=0x1 before the first rd_en;
  - empty=1 after the 16th pop.
- At count 8, hold wr_en and rd_en together for 40 cycles: count stays 8, pointers wrap at least twice, and output order matches input order.
- rd_en on an empty FIFO: underflow=1 and count stays 0. Then rst=1 for one cycle: underflow=0, and all outputs return to their reset values.
- At count 5, assert rst while wr_en=1: next cycle count=0, empty=1, and no data is visible on dout.
